dmem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between the pipeline MEM stage and an external loader/debug requester. The loader preloads and reads back array data, for example sort inputs and results. The block sits between the EX/MEM register outputs and `Data_Memory`. The pipeline has priority by default. A saturating starvation counter forces a loader slot and stalls the pipeline for one cycle when the loader has waited too long. Loader transactions use a req/ack handshake with a registered acknowledge and registered read data.

---
 rtl/dmem_port_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a loader/debug requester.
// Optional starvation guard (forced loader slot) enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_port_arbiter: STARVE_MAX must be in 1..255");
  end

  logic              cpu_active;
  logic              ld_eligible;
  logic              ld_grant;
  logic              ld_ack_q,   ld_ack_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  assign cpu_active  = cpu_memread | cpu_memwrite;
  // A request sitting in its own ack cycle has already been served.
  assign ld_eligible = ld_req & ~ld_ack_q;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       starve_forced;

  assign starve_forced = (starve_cnt_q == STARVE_MAX_C);
  assign ld_grant      = ld_eligible & (~cpu_active | starve_forced);
  assign cpu_stall     = ld_grant & cpu_active;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ld_eligible || ld_grant) begin
      starve_cnt_d = '0;
    end else if (cpu_active && !starve_forced) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign ld_grant  = ld_eligible & ~cpu_active;
  assign cpu_stall = 1'b0;
`endif

  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_memread  = cpu_memread;
    mem_memwrite = cpu_memwrite;
    if (ld_grant) begin
      mem_addr     = ld_addr;
      mem_wdata    = ld_wdata;
      mem_memread  = ~ld_we;
      mem_memwrite = ld_we;
    end
  end

  assign cpu_rdata = mem_rdata;

  always_comb begin
    ld_ack_d   = ld_grant;
    ld_rdata_d = ld_rdata_q;
    if (ld_grant && !ld_we) begin
      ld_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ack_q   <= 1'b0;
      ld_rdata_q <= '0;
    end else begin
      ld_ack_q   <= ld_ack_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  assign ld_ack   = ld_ack_q;
  assign ld_rdata = ld_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural Data_Memory stub.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_memread, cpu_memwrite;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_memread, mem_memwrite;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_rdata(mem_rdata)
  );

  // Data_Memory stub: 32 doublewords, combinational read, write on clock edge.
  logic [DW-1:0] mem [0:31];
  logic          pl_we;
  logic [4:0]    pl_idx;
  logic [DW-1:0] pl_val;
  logic          wr_clr;
  int            wr_cnt;

  assign mem_rdata = mem[mem_addr[7:3]];

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (mem_memwrite) mem[mem_addr[7:3]] <= mem_wdata;
    if (wr_clr) wr_cnt <= 0;
    else if (mem_memwrite) wr_cnt <= wr_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [DW-1:0] val);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
  endtask

  typedef struct {
    logic          c_rd, c_wr, l_req, l_we;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_ack;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Single-cycle arbitration cases with a fresh counter: CPU 0x40/0xC0DE, loader 0x48/0x1D.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h40, 64'hC0DE, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h40, 64'hC0DE, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h40, 64'hC0DE, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h48, 64'h1D,   1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h48, 64'h1D,   1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h40, 64'hC0DE, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h40, 64'hC0DE, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 64'hC0DE, 1'b0};

    idle_inputs();
    pl_we = 1'b0; pl_idx = '0; pl_val = '0; wr_clr = 1'b1;
    reset = 1'b1;
    preload(5'd1, 64'hAB);
    preload(5'd3, 64'h77);
    wr_clr = 1'b0;

    // Reset state with no requests.
    #1;
    check("rst_ld_ack", ld_ack, 0);
    check("rst_ld_rdata", ld_rdata, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_mem_rd_wr", {mem_memread, mem_memwrite}, 0);

    // Loader write 0x5 -> 0x10 requested during reset, released while CPU idle.
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 64'h10; ld_wdata = 64'h5;
    #1;
    check("rstrel_comb_wr", mem_memwrite, 1);
    check("rstrel_comb_addr", mem_addr, 64'h10);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rstrel_ack", ld_ack, 1);
    check("rstrel_mem10", mem[2], 64'h5);
    ld_req = 1'b0;
    @(posedge clk); #1;
    check("rstrel_ack_drop", ld_ack, 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_memread = vecs[i].c_rd; cpu_memwrite = vecs[i].c_wr;
      cpu_addr = 64'h40; cpu_wdata = 64'hC0DE;
      ld_req = vecs[i].l_req; ld_we = vecs[i].l_we; ld_addr = 64'h48; ld_wdata = 64'h1D;
      #1;
      check($sformatf("vec%0d_rd", i), mem_memread, vecs[i].e_rd);
      check($sformatf("vec%0d_wr", i), mem_memwrite, vecs[i].e_wr);
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("vec%0d_stall", i), cpu_stall, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ack", i), ld_ack, vecs[i].e_ack);
      idle_inputs();
      @(posedge clk);
    end

    // Same-address contention at 0x20: CPU store first, loader once CPU idles.
    @(negedge clk);
    cpu_memwrite = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'hC1;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 64'h20; ld_wdata = 64'hD2;
    @(posedge clk); #1;
    check("same_cpu_first", mem[4], 64'hC1);
    check("same_no_ack", ld_ack, 0);
    cpu_memwrite = 1'b0;
    @(posedge clk); #1;
    check("same_ld_ack", ld_ack, 1);
    check("same_ld_value", mem[4], 64'hD2);
    idle_inputs();
    @(posedge clk);

    // Three back-to-back loader writes, CPU idle, ld_req held.
    begin
      logic [5:0] ack_pat;
      int         n_done;
      ack_pat = '0; n_done = 0;
      @(negedge clk);
      wr_clr = 1'b1;
      @(negedge clk);
      wr_clr = 1'b0;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 64'h28; ld_wdata = 64'h11;
      for (int e = 0; e < 6; e++) begin
        @(posedge clk); #1;
        ack_pat[e] = ld_ack;
        if (ld_ack) begin
          n_done++;
          if (n_done == 1) begin ld_addr = 64'h30; ld_wdata = 64'h22; end
          else if (n_done == 2) begin ld_addr = 64'h38; ld_wdata = 64'h33; end
          else ld_req = 1'b0;
        end
      end
      check("b2b_ack_pattern", {58'd0, ack_pat}, 64'b010101);
      check("b2b_write_count", wr_cnt, 3);
      check("b2b_data", {mem[5][7:0], mem[6][7:0], mem[7][7:0]}, 64'h112233);
      idle_inputs();
    end

    // Loader read of 0x8 (0xAB) under continuous CPU loads of 0x18 (0x77).
    begin
      int bad_cycles;
      bad_cycles = 0;
      @(negedge clk);
      cpu_memread = 1'b1; cpu_addr = 64'h18;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 64'h8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 0; c < int'(SM); c++) begin
        #1;
        if (cpu_stall !== 1'b0 || mem_addr !== 64'h18 || cpu_rdata !== 64'h77) bad_cycles++;
        @(negedge clk);
      end
      check("starve_cpu_slots", bad_cycles, 0);
      #1;
      check("starve_forced_stall", cpu_stall, 1);
      check("starve_forced_addr", mem_addr, 64'h8);
      check("starve_forced_rd", mem_memread, 1);
      @(posedge clk); #1;
      check("starve_ack", ld_ack, 1);
      check("starve_rdata", ld_rdata, 64'hAB);
      ld_req = 1'b0;
      @(negedge clk); #1;
      check("starve_replay_stall", cpu_stall, 0);
      check("starve_replay_rdata", cpu_rdata, 64'h77);
      cpu_memread = 1'b0;
      @(posedge clk); #1;
      check("starve_ack_drop", ld_ack, 0);
`else
      for (int c = 0; c < 50; c++) begin
        #1;
        if (cpu_stall !== 1'b0 || ld_ack !== 1'b0) bad_cycles++;
        @(negedge clk);
      end
      check("noguard_no_stall_ack", bad_cycles, 0);
      cpu_memread = 1'b0;
      @(posedge clk); #1;
      check("noguard_ack", ld_ack, 1);
      check("noguard_rdata", ld_rdata, 64'hAB);
      ld_req = 1'b0;
      @(posedge clk); #1;
      check("noguard_ack_drop", ld_ack, 0);
`endif
      idle_inputs();
    end

    // Reset asserted in the grant cycle of a loader read of 0x18.
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 64'h18;
    #2 reset = 1'b1;
    #1;
    check("rstgrant_rdata_async", ld_rdata, 0);
    @(posedge clk); #1;
    check("rstgrant_ack", ld_ack, 0);
    ld_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstgrant_ack_after", ld_ack, 0);
    check("rstgrant_rdata_after", ld_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
